// File: rtl/register_file_32x32.sv
// register_file_32x32: 32 x 32-bit register file, synchronous write, registered dual read.
// Define REG_BYPASS_EN to forward same-edge write data to matching read ports.
module register_file_32x32 #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_CNT   = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter bit          ZERO_REG0 = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDR_R1,
  input  logic [ADDR_W-1:0] ADDR_R2,
  input  logic [ADDR_W-1:0] ADDR_W_IN,
  input  logic [DATA_W-1:0] DATA_W_IN,
  output logic [DATA_W-1:0] DATA_R1,
  output logic [DATA_W-1:0] DATA_R2
);

  logic [DATA_W-1:0]  regs [REG_CNT];
  logic [REG_CNT-1:0] wr_en;
  logic [DATA_W-1:0]  rd1_next;
  logic [DATA_W-1:0]  rd2_next;

  // One-hot write decode; gated by WRITE so an undriven address cannot enable anything.
  always_comb begin
    wr_en = '0;
    if (WRITE) begin
      for (int unsigned i = 0; i < REG_CNT; i++) begin
        wr_en[i] = (ADDR_W_IN == ADDR_W'(i)) && !(ZERO_REG0 && (i == 0));
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < REG_CNT; i++) begin
        if (wr_en[i]) begin
          regs[i] <= DATA_W_IN;
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] word;
    word = '0;
    for (int unsigned i = 0; i < REG_CNT; i++) begin
      if (addr == ADDR_W'(i)) begin
        word = regs[i];
      end
    end
    if (ZERO_REG0 && (addr == '0)) begin
      word = '0;
    end
    return word;
  endfunction

`ifdef REG_BYPASS_EN
  logic wr_any;
  assign wr_any = |wr_en;

  // wr_en already excludes a suppressed register-0 write, so no separate zero check here.
  always_comb begin
    rd1_next = rd_mux(ADDR_R1);
    rd2_next = rd_mux(ADDR_R2);
    if (wr_any && (ADDR_W_IN == ADDR_R1)) begin
      rd1_next = DATA_W_IN;
    end
    if (wr_any && (ADDR_W_IN == ADDR_R2)) begin
      rd2_next = DATA_W_IN;
    end
  end
`else
  always_comb begin
    rd1_next = rd_mux(ADDR_R1);
    rd2_next = rd_mux(ADDR_R2);
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATA_R1 <= '0;
      DATA_R2 <= '0;
    end else if (READ) begin
      DATA_R1 <= rd1_next;
      DATA_R2 <= rd2_next;
    end
  end

endmodule
